// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and way count for set_assoc_cache
package cache_pkg;

  localparam int NUM_WAYS = 2;

  typedef logic [1:0] cache_state_t;

  localparam cache_state_t ST_IDLE   = 2'd0;
  localparam cache_state_t ST_LOOKUP = 2'd1;
  localparam cache_state_t ST_MEM_RD = 2'd2;
  localparam cache_state_t ST_MEM_WR = 2'd3;

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one way of the cache: valid/tag/data arrays, hit compare, fill/write port
module cache_way #(
  parameter int SET_WIDTH  = 3,
  parameter int TAG_WIDTH  = 27,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SET_WIDTH-1:0]  set_idx,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  hit,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int SETS = 1 << SET_WIDTH;

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  // Valid bits are the only reset state; a write (fill or store hit) marks the line valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  // Tag and data storage; a store hit rewrites the same tag, so one port serves fill and store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[set_idx]  <= tag;
      data_q[set_idx] <= wr_data;
    end
  end

  assign valid   = valid_q[set_idx];
  assign hit     = valid && (tag_q[set_idx] == tag);
  assign rd_data = data_q[set_idx];

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - 2-way write-through no-write-allocate cache; CACHE_STATS_EN adds hit/miss counters
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SET_WIDTH    = 3,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 1 << SET_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  cache_state_t state;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;

  // lru[s] names the way to evict next in set s.
  logic [SETS-1:0] lru;

  logic [SET_WIDTH-1:0]  set_idx;
  logic [TAG_WIDTH-1:0]  tag;
  logic [NUM_WAYS-1:0]   way_hit;
  logic [NUM_WAYS-1:0]   way_valid;
  logic [NUM_WAYS-1:0]   way_wr;
  logic [DATA_WIDTH-1:0] way_rdata [NUM_WAYS];
  logic [DATA_WIDTH-1:0] way_wdata;
  logic                  any_hit;
  logic                  hit_way;
  logic                  victim;
  logic [DATA_WIDTH-1:0] hit_data;

  assign set_idx = req_addr[OFFSET_WIDTH +: SET_WIDTH];
  assign tag     = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cache_way #(
      .SET_WIDTH  (SET_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .set_idx (set_idx),
      .tag     (tag),
      .wr_en   (way_wr[g]),
      .wr_data (way_wdata),
      .hit     (way_hit[g]),
      .valid   (way_valid[g]),
      .rd_data (way_rdata[g])
    );
  end

  // Way 0 wins if both ever matched; fills only happen on a miss so that cannot arise.
  assign any_hit  = |way_hit;
  assign hit_way  = ~way_hit[0];
  assign hit_data = way_hit[0] ? way_rdata[0] : way_rdata[1];
  assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[set_idx]);

  assign mem_req   = (state == ST_MEM_RD) || (state == ST_MEM_WR);
  assign mem_we    = (state == ST_MEM_WR);
  assign mem_addr  = req_addr & WORD_MASK;
  assign mem_wdata = req_wdata;
  assign way_wdata = (state == ST_MEM_RD) ? mem_rdata : req_wdata;

  // Array write enables: store hit updates the hit way, a read fill updates the victim way.
  always_comb begin
    way_wr = '0;
    if (state == ST_LOOKUP && req_we && any_hit) begin
      way_wr[hit_way] = 1'b1;
    end else if (state == ST_MEM_RD && mem_ack) begin
      way_wr[victim] = 1'b1;
    end
  end

  // Control FSM with request capture, LRU update, load data and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      lru       <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (any_hit) begin
            lru[set_idx] <= ~hit_way;
            if (req_we) begin
              state <= ST_MEM_WR;
            end else begin
              cpu_rdata <= hit_data;
              cpu_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            state <= req_we ? ST_MEM_WR : ST_MEM_RD;
          end
        end
        ST_MEM_RD: begin
          if (mem_ack) begin
            lru[set_idx] <= ~victim;
            cpu_rdata    <= mem_rdata;
            cpu_ready    <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        ST_MEM_WR: begin
          if (mem_ack) begin
            cpu_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating lookup statistics, one count per LOOKUP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_LOOKUP) begin
      if (any_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
